// File: rtl/vram_dma_controller_if.sv
// Register-file and bus connections of the CGB VRAM DMA controller.
// The master side is the controller; the slave side is the surrounding system.
interface vram_dma_controller_if;
  // Special-register file side
  logic       DMA_start;
  logic [7:0] HDMA1;
  logic [7:0] HDMA2;
  logic [7:0] HDMA3;
  logic [7:0] HDMA4;
  logic [7:0] HDMA5;
  logic [1:0] STAT_mode;
  logic       lcd_on;
  logic       GDMA_finished;
  logic       hdma_active;
  logic [7:0] hdma5_status;
  // System bus (source) side
  logic        dma_req;
  logic        dma_gnt;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  rd_data;
  // VRAM (destination) side
  logic [12:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;

  modport master (
    input  DMA_start, HDMA1, HDMA2, HDMA3, HDMA4, HDMA5, STAT_mode, lcd_on,
    input  dma_gnt, rd_data,
    output GDMA_finished, hdma_active, hdma5_status,
    output dma_req, dma_addr, dma_rd,
    output vram_addr, vram_wdata, vram_we
  );

  modport slave (
    output DMA_start, HDMA1, HDMA2, HDMA3, HDMA4, HDMA5, STAT_mode, lcd_on,
    output dma_gnt, rd_data,
    input  GDMA_finished, hdma_active, hdma5_status,
    input  dma_req, dma_addr, dma_rd,
    input  vram_addr, vram_wdata, vram_we
  );
endinterface

// File: rtl/vram_dma_controller.sv
// CGB VRAM DMA sequencer: general-purpose (GDMA) and HBlank (HDMA) transfers
// of 16-byte blocks from the system bus into VRAM, two cycles per byte.
module vram_dma_controller (
  input  logic                   clk4_2,
  input  logic                   reset_n,
  vram_dma_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_HB = 3'd1,
    S_REQ     = 3'd2,
    S_RD      = 3'd3,
    S_WR      = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [15:0] r_src;
  logic [12:0] r_dst;
  logic [7:0]  r_blocks_left;
  logic [3:0]  r_byte_cnt;
  logic        r_mode;         // 1 = HBlank transfer
  logic        r_first;        // first WAIT_HB cycle after (re)start
  logic        r_cancel_pend;  // cancel seen while a block was in flight
  logic        r_cancelled;    // last HBlank transfer ended by cancel
  logic [1:0]  r_stat_prev;

  logic        w_in_block;
  logic        w_latch;
  logic        w_cancel_mid;
  logic        w_trigger;
  logic        w_to_cancel;
  logic [6:0]  w_blocks_m1;

  assign w_in_block   = (r_state == S_REQ) || (r_state == S_RD) || (r_state == S_WR);
  // A start in IDLE begins a transfer; an HBlank start while waiting re-latches.
  assign w_latch      = bus.DMA_start &&
                        ((r_state == S_IDLE) || ((r_state == S_WAIT_HB) && bus.HDMA5[7]));
  // A cancel during a block is only remembered; the block always finishes.
  assign w_cancel_mid = bus.DMA_start && !bus.HDMA5[7] && r_mode && w_in_block;
  // Mode-0 entry, or already in mode 0 right after the start.
  assign w_trigger    = bus.lcd_on && (bus.STAT_mode == 2'b00) &&
                        ((r_stat_prev != 2'b00) || r_first);
  assign w_blocks_m1  = r_blocks_left[6:0] - 7'd1;

  // State register
  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and bus/VRAM strobes
  always_comb begin
    w_next_state      = r_state;
    w_to_cancel       = 1'b0;
    bus.dma_req       = 1'b0;
    bus.dma_rd        = 1'b0;
    bus.dma_addr      = 16'h0000;
    bus.vram_we       = 1'b0;
    bus.vram_addr     = 13'h0000;
    bus.vram_wdata    = 8'h00;
    bus.GDMA_finished = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.DMA_start) w_next_state = bus.HDMA5[7] ? S_WAIT_HB : S_REQ;
      end
      S_WAIT_HB: begin
        if (bus.DMA_start && bus.HDMA5[7]) begin
          w_next_state = S_WAIT_HB;
        end else if (bus.DMA_start) begin
          w_next_state = S_IDLE;
          w_to_cancel  = 1'b1;
        end else if (w_trigger) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        bus.dma_req = 1'b1;
        if (bus.dma_gnt) w_next_state = S_RD;
      end
      S_RD: begin
        // Without a grant the read is held off; the state just waits.
        bus.dma_req  = 1'b1;
        bus.dma_addr = r_src;
        if (bus.dma_gnt) begin
          bus.dma_rd   = 1'b1;
          w_next_state = S_WR;
        end
      end
      S_WR: begin
        bus.dma_req    = 1'b1;
        bus.vram_we    = 1'b1;
        bus.vram_addr  = r_dst;
        bus.vram_wdata = bus.rd_data;
        if (r_byte_cnt != 4'hF) begin
          w_next_state = S_RD;
        end else if (r_blocks_left == 8'd1) begin
          w_next_state = S_FIN;
        end else if (!r_mode) begin
          w_next_state = S_RD;
        end else if (r_cancel_pend || w_cancel_mid) begin
          w_next_state = S_IDLE;
          w_to_cancel  = 1'b1;
        end else begin
          w_next_state = S_WAIT_HB;
        end
      end
      S_FIN: begin
        bus.GDMA_finished = 1'b1;
        w_next_state      = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Transfer parameters, address counters and cancel bookkeeping
  always_ff @(posedge clk4_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_src         <= 16'h0000;
      r_dst         <= 13'h0000;
      r_blocks_left <= 8'h00;
      r_byte_cnt    <= 4'h0;
      r_mode        <= 1'b0;
      r_first       <= 1'b0;
      r_cancel_pend <= 1'b0;
      r_cancelled   <= 1'b0;
      r_stat_prev   <= 2'b00;
    end else begin
      r_stat_prev <= bus.STAT_mode;
      if (w_latch) begin
        r_src         <= {bus.HDMA1, bus.HDMA2[7:4], 4'h0};
        r_dst         <= {bus.HDMA3[4:0], bus.HDMA4[7:4], 4'h0};
        r_blocks_left <= {1'b0, bus.HDMA5[6:0]} + 8'd1;
        r_byte_cnt    <= 4'h0;
        r_mode        <= bus.HDMA5[7];
        r_first       <= bus.HDMA5[7];
        r_cancel_pend <= 1'b0;
        r_cancelled   <= 1'b0;
      end else begin
        if (r_state == S_WAIT_HB) r_first <= 1'b0;
        if (w_cancel_mid)         r_cancel_pend <= 1'b1;
        if (w_to_cancel) begin
          r_cancelled   <= 1'b1;
          r_cancel_pend <= 1'b0;
        end
        if (r_state == S_WR) begin
          r_src      <= r_src + 16'd1;
          r_dst      <= r_dst + 13'd1;
          r_byte_cnt <= r_byte_cnt + 4'd1;
          if (r_byte_cnt == 4'hF) r_blocks_left <= r_blocks_left - 8'd1;
        end
      end
    end
  end

  assign bus.hdma_active  = r_mode && ((r_state == S_WAIT_HB) || w_in_block);
  assign bus.hdma5_status = r_cancelled ? {1'b1, w_blocks_m1} :
                            ((r_state == S_IDLE) || (r_state == S_FIN)) ? 8'hFF :
                            {1'b0, w_blocks_m1};

endmodule

// File: tb/tb_vram_dma_controller.sv
// Directed bench for vram_dma_controller: GDMA, HDMA pacing, cancel,
// address wrap, grant stall and asynchronous reset.
module tb_vram_dma_controller;

  logic clk4_2  = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk4_2 = ~clk4_2;

  vram_dma_controller_if bus ();

  vram_dma_controller dut (
    .clk4_2  (clk4_2),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [12:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          wq_cyc[$];
  logic [15:0] rq_addr[$];
  int          fin_cyc[$];
  logic        fin_req[$];
  int          req_fall[$];
  int          rd_nogrant = 0;
  logic        prev_req   = 1'b0;

  // Source memory contents, a fixed function of the address
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk4_2) cyc <= cyc + 1;

  // Source memory: data valid the cycle after the read strobe
  always @(posedge clk4_2) begin
    if (!reset_n)        bus.rd_data <= 8'h00;
    else if (bus.dma_rd) bus.rd_data <= mem_byte(bus.dma_addr);
  end

  // Transaction monitor, sampled mid-cycle
  always @(negedge clk4_2) begin
    if (reset_n) begin
      if (bus.vram_we) begin
        wq_addr.push_back(bus.vram_addr);
        wq_data.push_back(bus.vram_wdata);
        wq_cyc.push_back(cyc);
        $display("  cyc %0d: vram[%04h] <= %02h", cyc, bus.vram_addr, bus.vram_wdata);
      end
      if (bus.dma_rd) rq_addr.push_back(bus.dma_addr);
      if (bus.dma_rd && !bus.dma_gnt) rd_nogrant <= rd_nogrant + 1;
      if (bus.GDMA_finished) begin
        fin_cyc.push_back(cyc);
        fin_req.push_back(bus.dma_req);
      end
      if (prev_req && !bus.dma_req) req_fall.push_back(cyc);
      prev_req <= bus.dma_req;
    end else begin
      prev_req <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk4_2);
    #1;
  endtask

  task automatic start_dma(input logic [7:0] h1, input logic [7:0] h2, input logic [7:0] h3,
                           input logic [7:0] h4, input logic [7:0] h5, output int c0);
    bus.HDMA1 = h1; bus.HDMA2 = h2; bus.HDMA3 = h3; bus.HDMA4 = h4; bus.HDMA5 = h5;
    bus.DMA_start = 1'b1;
    c0 = cyc;
    step();
    bus.DMA_start = 1'b0;
  endtask

  task automatic wait_fin(input int fb, input int budget, input string tag);
    int n;
    n = 0;
    while (fin_cyc.size() <= fb && n < budget) begin
      step();
      n++;
    end
    check_vec(tag, (fin_cyc.size() > fb) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // One LCD line: mode 2, mode 3, then a long HBlank
  task automatic hblank();
    bus.STAT_mode = 2'd2; repeat (4) step();
    bus.STAT_mode = 2'd3; repeat (4) step();
    bus.STAT_mode = 2'd0; repeat (40) step();
  endtask

  function automatic int qi(input int q[$], input int idx);
    return (idx >= 0 && idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, wb, rb, fb, qb, errs, nrd;
    logic [7:0] exp_stat [3];
    exp_stat[0] = 8'h01; exp_stat[1] = 8'h00; exp_stat[2] = 8'hFF;

    bus.DMA_start = 1'b0;
    bus.HDMA1 = 8'h00; bus.HDMA2 = 8'h00; bus.HDMA3 = 8'h00; bus.HDMA4 = 8'h00; bus.HDMA5 = 8'h00;
    bus.STAT_mode = 2'd0; bus.lcd_on = 1'b0; bus.dma_gnt = 1'b1;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Reset state
    @(negedge clk4_2);
    check_vec("rst_status", bus.hdma5_status, 8'hFF);
    check_vec("rst_req", bus.dma_req, 1'b0);
    check_vec("rst_we", bus.vram_we, 1'b0);
    check_vec("rst_fin", bus.GDMA_finished, 1'b0);
    check_vec("rst_active", bus.hdma_active, 1'b0);

    // GDMA, 2 blocks, constant grant
    step();
    wb = wq_addr.size(); fb = fin_cyc.size();
    start_dma(8'hC0, 8'h00, 8'h80, 8'h00, 8'h01, c0);
    @(negedge clk4_2);
    check_vec("gdma_req_c1", bus.dma_req, 1'b1);
    wait_fin(fb, 120, "gdma_done");
    check_vec("gdma_fin_cyc", qi(fin_cyc, fb) - c0, 66);
    check_vec("gdma_fin_req", (fin_req.size() > fb) ? fin_req[fb] : 1'b1, 1'b0);
    check_vec("gdma_nwr", wq_addr.size() - wb, 32);
    check_vec("gdma_first_we", qi(wq_cyc, wb) - c0, 3);
    check_vec("gdma_last_we", qi(wq_cyc, wb + 31) - c0, 65);
    errs = 0;
    for (int i = 0; i < 32 && wb + i < wq_addr.size(); i++)
      if (wq_addr[wb+i] !== 13'(i) || wq_data[wb+i] !== mem_byte(16'hC000 + 16'(i))) errs++;
    check_vec("gdma_data", errs, 0);
    @(negedge clk4_2);
    check_vec("gdma_status", bus.hdma5_status, 8'hFF);

    // HDMA, 3 blocks paced by HBlank
    step();
    bus.lcd_on = 1'b1; bus.STAT_mode = 2'd2;
    wb = wq_addr.size(); fb = fin_cyc.size(); qb = req_fall.size();
    start_dma(8'hD0, 8'h00, 8'h01, 8'h00, 8'h82, c0);
    @(negedge clk4_2);
    check_vec("hdma_active0", bus.hdma_active, 1'b1);
    check_vec("hdma_wait_req", bus.dma_req, 1'b0);
    check_vec("hdma_status0", bus.hdma5_status, 8'h02);
    for (int r = 0; r < 3; r++) begin
      hblank();
      @(negedge clk4_2);
      check_vec($sformatf("hdma_nwr%0d", r), wq_addr.size() - wb, 32'(16 * (r + 1)));
      check_vec($sformatf("hdma_status%0d", r + 1), bus.hdma5_status, exp_stat[r]);
      check_vec($sformatf("hdma_active%0d", r + 1), bus.hdma_active, (r < 2) ? 1'b1 : 1'b0);
      if (r == 0) check_vec("hdma_req_drop", qi(req_fall, qb), qi(wq_cyc, wb + 15) + 1);
    end
    check_vec("hdma_fin", fin_cyc.size() - fb, 1);
    errs = 0;
    for (int i = 0; i < 48 && wb + i < wq_addr.size(); i++)
      if (wq_addr[wb+i] !== 13'h0100 + 13'(i) || wq_data[wb+i] !== mem_byte(16'hD000 + 16'(i))) errs++;
    check_vec("hdma_data", errs, 0);

    // Cancel after one HBlank block
    step();
    bus.STAT_mode = 2'd2;
    wb = wq_addr.size(); fb = fin_cyc.size(); rb = rq_addr.size();
    start_dma(8'hD1, 8'h00, 8'h02, 8'h00, 8'h83, c0);
    hblank();
    @(negedge clk4_2);
    check_vec("cancel_nwr1", wq_addr.size() - wb, 16);
    check_vec("cancel_status1", bus.hdma5_status, 8'h02);
    step();
    bus.HDMA5 = 8'h00; bus.DMA_start = 1'b1;
    step();
    bus.DMA_start = 1'b0;
    @(negedge clk4_2);
    check_vec("cancel_status", bus.hdma5_status, 8'h82);
    check_vec("cancel_active", bus.hdma_active, 1'b0);
    hblank();
    @(negedge clk4_2);
    check_vec("cancel_nwr2", wq_addr.size() - wb, 16);
    check_vec("cancel_nrd", rq_addr.size() - rb, 16);
    check_vec("cancel_nofin", fin_cyc.size() - fb, 0);
    check_vec("cancel_status_hold", bus.hdma5_status, 8'h82);

    // Address wrap-around
    step();
    wb = wq_addr.size(); fb = fin_cyc.size(); rb = rq_addr.size();
    start_dma(8'hFF, 8'hF0, 8'h1F, 8'hF0, 8'h01, c0);
    wait_fin(fb, 120, "wrap_done");
    check_vec("wrap_nrd", rq_addr.size() - rb, 32);
    check_vec("wrap_src16", (rb + 16 < rq_addr.size()) ? rq_addr[rb+16] : 16'hDEAD, 16'h0000);
    check_vec("wrap_dst16", (wb + 16 < wq_addr.size()) ? wq_addr[wb+16] : 13'h1ABC, 13'h0000);
    errs = 0;
    for (int i = 0; i < 32 && rb + i < rq_addr.size() && wb + i < wq_addr.size(); i++) begin
      if (rq_addr[rb+i] !== 16'hFFF0 + 16'(i)) errs++;
      if (wq_addr[wb+i] !== 13'h1FF0 + 13'(i)) errs++;
      if (wq_data[wb+i] !== mem_byte(16'hFFF0 + 16'(i))) errs++;
    end
    check_vec("wrap_addrs", errs, 0);

    // Grant dropped for 5 cycles mid-block, starting in a read cycle
    step();
    wb = wq_addr.size(); fb = fin_cyc.size(); rb = rq_addr.size();
    nrd = rd_nogrant;
    start_dma(8'h40, 8'h00, 8'h02, 8'h00, 8'h00, c0);
    for (int n = 0; n < 100 && wq_addr.size() - wb < 5; n++) step();
    bus.dma_gnt = 1'b0;
    repeat (5) step();
    bus.dma_gnt = 1'b1;
    wait_fin(fb, 120, "stall_done");
    check_vec("stall_fin_cyc", qi(fin_cyc, fb) - c0, 39);
    check_vec("stall_nwr", wq_addr.size() - wb, 16);
    check_vec("stall_nrd", rq_addr.size() - rb, 16);
    check_vec("stall_rd_nogrant", rd_nogrant - nrd, 0);
    errs = 0;
    for (int i = 0; i < 16 && wb + i < wq_addr.size(); i++)
      if (wq_addr[wb+i] !== 13'h0200 + 13'(i) || wq_data[wb+i] !== mem_byte(16'h4000 + 16'(i))) errs++;
    check_vec("stall_data", errs, 0);

    // Asynchronous reset in the middle of a GDMA
    step();
    fb = fin_cyc.size();
    start_dma(8'hC0, 8'h00, 8'h00, 8'h00, 8'h03, c0);
    repeat (20) step();
    check_vec("rst_pre_req", bus.dma_req, 1'b1);
    reset_n = 1'b0;
    #1;
    check_vec("rst_mid_req", bus.dma_req, 1'b0);
    check_vec("rst_mid_rd", bus.dma_rd, 1'b0);
    check_vec("rst_mid_we", bus.vram_we, 1'b0);
    check_vec("rst_mid_status", bus.hdma5_status, 8'hFF);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    @(negedge clk4_2);
    check_vec("rst_post_req", bus.dma_req, 1'b0);
    check_vec("rst_post_active", bus.hdma_active, 1'b0);
    check_vec("rst_post_status", bus.hdma5_status, 8'hFF);
    check_vec("rst_post_nofin", fin_cyc.size() - fb, 0);
    step();
    start_dma(8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, c0);
    wait_fin(fb, 80, "rst_restart_done");
    check_vec("rst_restart_cyc", qi(fin_cyc, fb) - c0, 34);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
